// File: rtl/in_ports_pkg.sv
// Shared widths for the byter CPU port banks (input and output side).
// Each external port is {strobe, data}; the strobe sits just above the data byte.
package in_ports_pkg;

  localparam int DATA_W     = 8;
  localparam int N_PORTS    = 16;
  localparam int ADDR_W     = 4;
  localparam int STROBE_BIT = DATA_W;
  localparam int PORT_W     = DATA_W + 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PORT_W-1:0] port_t;
  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic strobe_of(input port_t p);
    return p[STROBE_BIT];
  endfunction

  function automatic data_t data_of(input port_t p);
    return p[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/in_port_slot.sv
// One input port: strobe edge detect, holding register, pending and overrun flags.
// A read of this slot consumes the byte; a same-cycle capture still lands.
module in_port_slot
  import in_ports_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  port_t i_port,
  input  logic  i_rd,
  output data_t o_hold,
  output logic  o_pend,
  output logic  o_ovr
);

  logic  r_strobe_prev;
  data_t r_hold;
  logic  r_pend;
  logic  r_ovr;
  logic  w_rise;

  // strobe_prev clears on reset, so a strobe held across release still captures once
  assign w_rise = strobe_of(i_port) & ~r_strobe_prev;

  // NOTE: sequential state uses non-blocking assignments so every slot and the
  // top-level output registers all sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe_prev <= 1'b0;
      r_hold        <= '0;
      r_pend        <= 1'b0;
      r_ovr         <= 1'b0;
    end else begin
      r_strobe_prev <= strobe_of(i_port);
      if (w_rise) begin
        r_hold <= data_of(i_port);
        r_pend <= 1'b1;
        // A concurrent read consumed the old byte, so nothing was overrun
        if (i_rd)
          r_ovr <= 1'b0;
        else if (r_pend)
          r_ovr <= 1'b1;
      end else if (i_rd) begin
        r_pend <= 1'b0;
        r_ovr  <= 1'b0;
      end
    end
  end

  assign o_hold = r_hold;
  assign o_pend = r_pend;
  assign o_ovr  = r_ovr;

endmodule

// File: rtl/in_ports.sv
// Input-port bank: sixteen strobed capture slots plus a registered CPU read path.
// Read data appears one cycle after enable; the read clears the addressed slot.
module in_ports
  import in_ports_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [PORT_W-1:0]    in_00,
  input  logic [PORT_W-1:0]    in_01,
  input  logic [PORT_W-1:0]    in_02,
  input  logic [PORT_W-1:0]    in_03,
  input  logic [PORT_W-1:0]    in_04,
  input  logic [PORT_W-1:0]    in_05,
  input  logic [PORT_W-1:0]    in_06,
  input  logic [PORT_W-1:0]    in_07,
  input  logic [PORT_W-1:0]    in_08,
  input  logic [PORT_W-1:0]    in_09,
  input  logic [PORT_W-1:0]    in_10,
  input  logic [PORT_W-1:0]    in_11,
  input  logic [PORT_W-1:0]    in_12,
  input  logic [PORT_W-1:0]    in_13,
  input  logic [PORT_W-1:0]    in_14,
  input  logic [PORT_W-1:0]    in_15,
  output logic [PORT_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 out_ovr,
  output logic [N_PORTS-1:0]   pending
);

  port_t               w_in   [N_PORTS];
  data_t               w_hold [N_PORTS];
  logic  [N_PORTS-1:0] w_pend;
  logic  [N_PORTS-1:0] w_ovr;
  logic  [N_PORTS-1:0] w_rd;

  port_t r_out_data;
  logic  r_out_valid;
  logic  r_out_ovr;

  assign w_in[0]  = in_00;
  assign w_in[1]  = in_01;
  assign w_in[2]  = in_02;
  assign w_in[3]  = in_03;
  assign w_in[4]  = in_04;
  assign w_in[5]  = in_05;
  assign w_in[6]  = in_06;
  assign w_in[7]  = in_07;
  assign w_in[8]  = in_08;
  assign w_in[9]  = in_09;
  assign w_in[10] = in_10;
  assign w_in[11] = in_11;
  assign w_in[12] = in_12;
  assign w_in[13] = in_13;
  assign w_in[14] = in_14;
  assign w_in[15] = in_15;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_slot
    assign w_rd[g] = enable && (addr == ADDR_W'(g));

    in_port_slot u_slot (
      .clk    (clk),
      .reset  (reset),
      .i_port (w_in[g]),
      .i_rd   (w_rd[g]),
      .o_hold (w_hold[g]),
      .o_pend (w_pend[g]),
      .o_ovr  (w_ovr[g])
    );
  end

  // Read path samples the pre-edge slot state, so a same-cycle capture is not visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ovr   <= 1'b0;
    end else begin
      r_out_valid <= enable;
      if (enable) begin
        r_out_data <= {w_pend[addr], w_hold[addr]};
        r_out_ovr  <= w_ovr[addr];
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ovr   = r_out_ovr;
  assign pending   = w_pend;

endmodule
